// File: rtl/reg_bus_pkg.sv
// rtl/reg_bus_pkg.sv - shared types, register map constants and access rules for the register bus arbiter
package reg_bus_pkg;

    localparam int REG_ADDR_W = 6;
    localparam int REG_DATA_W = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_XFER = 2'd1,
        ST_RESP = 2'd2,
        ST_ACK  = 2'd3
    } bus_state_e;

    localparam logic [REG_ADDR_W-1:0] BCAST_ALL      = 6'h01;
    localparam logic [REG_ADDR_W-1:0] BCAST_ROT      = 6'h02;
    localparam logic [REG_ADDR_W-1:0] BCAST_DRV      = 6'h03;
    localparam logic [REG_ADDR_W-1:0] DRIVE0_CONTROL = 6'h04;
    localparam logic [REG_ADDR_W-1:0] LED_TEST       = 6'h25;
    localparam logic [REG_ADDR_W-1:0] REG_MAX_ADDR   = LED_TEST;

    // Status/angle registers that the register file never accepts writes to.
    function automatic logic is_read_only(input logic [REG_ADDR_W-1:0] addr);
        case (addr)
            6'h05, 6'h07, 6'h09, 6'h0B, 6'h0D, 6'h0F,
            6'h10, 6'h12, 6'h14, 6'h15, 6'h17, 6'h19,
            6'h1A, 6'h1C, 6'h1E, 6'h1F, 6'h24: is_read_only = 1'b1;
            default:                          is_read_only = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/rr_arb2.sv
// rtl/rr_arb2.sv - two-input round-robin grant selection holding the last tie winner
module rr_arb2 (
    input  logic       clock,
    input  logic       reset,
    input  logic [1:0] req_i,
    input  logic       take_i,
    output logic       grant_o
);

    logic last_grant_q;
    logic last_grant_d;

    always_comb begin
        if (req_i == 2'b11) begin
            grant_o = ~last_grant_q;
        end else begin
            grant_o = req_i[1] & ~req_i[0];
        end
    end

    // Only a contested grant moves the pointer; it decides the next tie.
    always_comb begin
        last_grant_d = last_grant_q;
        if (take_i && (req_i == 2'b11)) begin
            last_grant_d = grant_o;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            last_grant_q <= 1'b1;
        end else begin
            last_grant_q <= last_grant_d;
        end
    end

endmodule

// File: rtl/reg_bus_arbiter.sv
// rtl/reg_bus_arbiter.sv - serialises host bridge and supervisor accesses onto the register file port
module reg_bus_arbiter #(
    parameter int                ADDR_W   = 6,
    parameter int                DATA_W   = 8,
    parameter logic [ADDR_W-1:0] MAX_ADDR = ADDR_W'('h25)
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              r0_req,
    input  logic              r0_we,
    input  logic [ADDR_W-1:0] r0_addr,
    input  logic [DATA_W-1:0] r0_wdata,
    output logic              r0_ack,
    output logic              r0_err,
    output logic [DATA_W-1:0] r0_rdata,
    input  logic              r1_req,
    input  logic              r1_we,
    input  logic [ADDR_W-1:0] r1_addr,
    input  logic [DATA_W-1:0] r1_wdata,
    output logic              r1_ack,
    output logic              r1_err,
    output logic [DATA_W-1:0] r1_rdata,
    output logic [ADDR_W-1:0] reg_address,
    output logic              reg_write_en,
    output logic [DATA_W-1:0] reg_wr_data,
    output logic              reg_read_en,
    input  logic [DATA_W-1:0] reg_rd_data,
    output logic              busy
);
    import reg_bus_pkg::*;

    bus_state_e        state_q, state_d;
    logic              cmd_we_q, cmd_we_d;
    logic [ADDR_W-1:0] cmd_addr_q, cmd_addr_d;
    logic [DATA_W-1:0] cmd_wdata_q, cmd_wdata_d;
    logic              cmd_id_q, cmd_id_d;
    logic              cmd_illegal_q, cmd_illegal_d;
    logic [DATA_W-1:0] r0_rdata_q, r0_rdata_d;
    logic [DATA_W-1:0] r1_rdata_q, r1_rdata_d;

    logic              take;
    logic              grant_id;
    logic              sel_we;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_wdata;

    assign take = (state_q == ST_IDLE) && (r0_req || r1_req);

    rr_arb2 u_arb (
        .clock   (clock),
        .reset   (reset),
        .req_i   ({r1_req, r0_req}),
        .take_i  (take),
        .grant_o (grant_id)
    );

    assign sel_we    = grant_id ? r1_we    : r0_we;
    assign sel_addr  = grant_id ? r1_addr  : r0_addr;
    assign sel_wdata = grant_id ? r1_wdata : r0_wdata;

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q       <= ST_IDLE;
            cmd_we_q      <= 1'b0;
            cmd_addr_q    <= '0;
            cmd_wdata_q   <= '0;
            cmd_id_q      <= 1'b0;
            cmd_illegal_q <= 1'b0;
            r0_rdata_q    <= '0;
            r1_rdata_q    <= '0;
        end else begin
            state_q       <= state_d;
            cmd_we_q      <= cmd_we_d;
            cmd_addr_q    <= cmd_addr_d;
            cmd_wdata_q   <= cmd_wdata_d;
            cmd_id_q      <= cmd_id_d;
            cmd_illegal_q <= cmd_illegal_d;
            r0_rdata_q    <= r0_rdata_d;
            r1_rdata_q    <= r1_rdata_d;
        end
    end

    // ACK always returns to IDLE, so a req still held after ack is sampled afresh.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (r0_req || r1_req) state_d = ST_XFER;
            ST_XFER: state_d = ST_RESP;
            ST_RESP: state_d = ST_ACK;
            ST_ACK:  state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        cmd_we_d      = cmd_we_q;
        cmd_addr_d    = cmd_addr_q;
        cmd_wdata_d   = cmd_wdata_q;
        cmd_id_d      = cmd_id_q;
        cmd_illegal_d = cmd_illegal_q;
        r0_rdata_d    = r0_rdata_q;
        r1_rdata_d    = r1_rdata_q;
        if (take) begin
            cmd_we_d      = sel_we;
            cmd_addr_d    = sel_addr;
            cmd_wdata_d   = sel_wdata;
            cmd_id_d      = grant_id;
            cmd_illegal_d = (sel_addr > MAX_ADDR) ||
                            (sel_we && ((sel_addr == '0) || is_read_only(sel_addr)));
        end
        // Register file read data lands one cycle after the strobe, i.e. in RESP.
        if ((state_q == ST_RESP) && !cmd_we_q) begin
            if (cmd_id_q) begin
                r1_rdata_d = cmd_illegal_q ? '0 : reg_rd_data;
            end else begin
                r0_rdata_d = cmd_illegal_q ? '0 : reg_rd_data;
            end
        end
    end

    always_comb begin
        reg_address  = '0;
        reg_write_en = 1'b0;
        reg_read_en  = 1'b0;
        reg_wr_data  = '0;
        r0_ack       = 1'b0;
        r0_err       = 1'b0;
        r1_ack       = 1'b0;
        r1_err       = 1'b0;
        busy         = (state_q != ST_IDLE);
        case (state_q)
            ST_XFER: begin
                if (!cmd_illegal_q) begin
                    reg_address  = cmd_addr_q;
                    reg_write_en = cmd_we_q;
                    reg_read_en  = !cmd_we_q;
                    reg_wr_data  = cmd_we_q ? cmd_wdata_q : '0;
                end
            end
            ST_ACK: begin
                r0_ack = !cmd_id_q;
                r0_err = !cmd_id_q && cmd_illegal_q;
                r1_ack = cmd_id_q;
                r1_err = cmd_id_q && cmd_illegal_q;
            end
            default: ;
        endcase
    end

    assign r0_rdata = r0_rdata_q;
    assign r1_rdata = r1_rdata_q;

endmodule

// File: tb/tb_reg_bus_arbiter.sv
// tb/tb_reg_bus_arbiter.sv - scoreboard bench for reg_bus_arbiter
module tb_reg_bus_arbiter;

    typedef struct {
        bit         we;
        logic [5:0] addr;
        logic [7:0] wdata;
    } strobe_t;

    typedef struct {
        bit         id;
        bit         err;
        logic [7:0] rdata;
    } ack_t;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       r0_req = 1'b0, r0_we = 1'b0;
    logic [5:0] r0_addr = '0;
    logic [7:0] r0_wdata = '0;
    logic       r0_ack, r0_err;
    logic [7:0] r0_rdata;
    logic       r1_req = 1'b0, r1_we = 1'b0;
    logic [5:0] r1_addr = '0;
    logic [7:0] r1_wdata = '0;
    logic       r1_ack, r1_err;
    logic [7:0] r1_rdata;
    logic [5:0] reg_address;
    logic       reg_write_en, reg_read_en;
    logic [7:0] reg_wr_data;
    logic [7:0] reg_rd_data = '0;
    logic       busy;

    int         n_tests = 0;
    int         n_fail  = 0;
    int         cyc     = 0;
    bit         mon_en  = 1'b0;
    strobe_t    sq[$];
    ack_t       aq[$];
    logic [7:0] exp_rd[2];

    reg_bus_arbiter dut (
        .clock        (clock),
        .reset        (reset),
        .r0_req       (r0_req),
        .r0_we        (r0_we),
        .r0_addr      (r0_addr),
        .r0_wdata     (r0_wdata),
        .r0_ack       (r0_ack),
        .r0_err       (r0_err),
        .r0_rdata     (r0_rdata),
        .r1_req       (r1_req),
        .r1_we        (r1_we),
        .r1_addr      (r1_addr),
        .r1_wdata     (r1_wdata),
        .r1_ack       (r1_ack),
        .r1_err       (r1_err),
        .r1_rdata     (r1_rdata),
        .reg_address  (reg_address),
        .reg_write_en (reg_write_en),
        .reg_wr_data  (reg_wr_data),
        .reg_read_en  (reg_read_en),
        .reg_rd_data  (reg_rd_data),
        .busy         (busy)
    );

    always #5 clock = ~clock;
    always @(posedge clock) cyc = cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic bit tb_read_only(input logic [5:0] a);
        case (a)
            6'h05, 6'h07, 6'h09, 6'h0B, 6'h0D, 6'h0F, 6'h10, 6'h12, 6'h14,
            6'h15, 6'h17, 6'h19, 6'h1A, 6'h1C, 6'h1E, 6'h1F, 6'h24: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic [7:0] rd_model(input logic [5:0] a);
        return (a == 6'h0F) ? 8'h5A : {2'b01, a};
    endfunction

    // Register file model: registered read, garbage when not strobed.
    always @(posedge clock) begin
        if (reg_read_en) reg_rd_data <= rd_model(reg_address);
        else             reg_rd_data <= 8'hEE;
    end

    task automatic expect_txn(input bit id, input bit we, input logic [5:0] addr, input logic [7:0] wdata);
        bit ill;
        ill = (addr > 6'h25) || (we && ((addr == 6'h00) || tb_read_only(addr)));
        if (!ill) sq.push_back('{we: we, addr: addr, wdata: we ? wdata : 8'h00});
        if (!we) exp_rd[id] = ill ? 8'h00 : rd_model(addr);
        aq.push_back('{id: id, err: ill, rdata: exp_rd[id]});
    endtask

    // Called at posedge+1; returns at posedge+1 of the cycle after ack with req still high.
    task automatic issue(input bit id, input bit we, input logic [5:0] addr, input logic [7:0] wdata,
                         input bit lat_chk);
        int  c0;
        bit  seen;
        if (id) begin r1_we = we; r1_addr = addr; r1_wdata = wdata; r1_req = 1'b1; end
        else    begin r0_we = we; r0_addr = addr; r0_wdata = wdata; r0_req = 1'b1; end
        c0   = cyc;
        seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clock);
            if (id ? r1_ack : r0_ack) begin
                seen = 1'b1;
                break;
            end
        end
        check(id ? "r1_ack_timeout" : "r0_ack_timeout", 32'(seen), 32'd1);
        if (seen && lat_chk) check("ack_latency", 32'(cyc - c0), 32'd3);
        @(posedge clock);
        #1;
    endtask

    task automatic drop(input bit id);
        if (id) r1_req = 1'b0;
        else    r0_req = 1'b0;
    endtask

    always @(negedge clock) begin
        if (mon_en) begin
            if (reg_write_en || reg_read_en) begin
                check("strobe_both", 32'(reg_write_en && reg_read_en), 32'd0);
                if (sq.size() == 0) begin
                    check("unexpected_strobe", 32'd1, 32'd0);
                end else begin
                    strobe_t s;
                    s = sq.pop_front();
                    check("strobe_we", 32'(reg_write_en), 32'(s.we));
                    check("strobe_addr", 32'(reg_address), 32'(s.addr));
                    check("strobe_wdata", 32'(reg_wr_data), 32'(s.wdata));
                end
            end else begin
                check("idle_addr", 32'(reg_address), 32'd0);
                check("idle_wdata", 32'(reg_wr_data), 32'd0);
            end
            check("r0_err_no_ack", 32'(r0_err && !r0_ack), 32'd0);
            check("r1_err_no_ack", 32'(r1_err && !r1_ack), 32'd0);
            if (r0_ack || r1_ack) begin
                check("ack_both", 32'(r0_ack && r1_ack), 32'd0);
                if (aq.size() == 0) begin
                    check("unexpected_ack", 32'd1, 32'd0);
                end else begin
                    ack_t e;
                    e = aq.pop_front();
                    check("ack_id", 32'(r1_ack), 32'(e.id));
                    check("ack_err", 32'(r1_ack ? r1_err : r0_err), 32'(e.err));
                    check("ack_rdata", 32'(r1_ack ? r1_rdata : r0_rdata), 32'(e.rdata));
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        exp_rd[0] = 8'h00;
        exp_rd[1] = 8'h00;
        repeat (3) @(posedge clock);
        @(negedge clock);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_strobes", 32'({reg_write_en, reg_read_en}), 32'd0);
        check("rst_acks", 32'({r0_ack, r0_err, r1_ack, r1_err}), 32'd0);
        check("rst_rdata", 32'({r0_rdata, r1_rdata}), 32'd0);
        check("rst_addr", 32'(reg_address), 32'd0);
        @(posedge clock);
        #1;
        reset  = 1'b0;
        mon_en = 1'b1;

        // Single write, then single read
        expect_txn(0, 1, 6'h04, 8'hC5);
        issue(0, 1, 6'h04, 8'hC5, 1);
        drop(0);
        expect_txn(1, 0, 6'h0F, 8'h00);
        issue(1, 0, 6'h0F, 8'h00, 1);
        drop(1);

        // Continuous contention: grants must alternate starting with r0
        expect_txn(0, 0, 6'h0F, 8'h00);
        expect_txn(1, 1, 6'h02, 8'h77);
        expect_txn(0, 1, 6'h08, 8'h33);
        expect_txn(1, 0, 6'h11, 8'h00);
        expect_txn(0, 0, 6'h24, 8'h00);
        expect_txn(1, 1, 6'h25, 8'h99);
        fork
            begin
                issue(0, 0, 6'h0F, 8'h00, 0);
                issue(0, 1, 6'h08, 8'h33, 0);
                issue(0, 0, 6'h24, 8'h00, 0);
                drop(0);
            end
            begin
                issue(1, 1, 6'h02, 8'h77, 0);
                issue(1, 0, 6'h11, 8'h00, 0);
                issue(1, 1, 6'h25, 8'h99, 0);
                drop(1);
            end
        join
        @(posedge clock);
        #1;

        // Illegal accesses, then a legal broadcast write
        expect_txn(0, 1, 6'h05, 8'h12);
        issue(0, 1, 6'h05, 8'h12, 1);
        drop(0);
        expect_txn(0, 1, 6'h00, 8'h34);
        issue(0, 1, 6'h00, 8'h34, 1);
        drop(0);
        expect_txn(1, 0, 6'h30, 8'h00);
        issue(1, 0, 6'h30, 8'h00, 1);
        drop(1);
        expect_txn(0, 1, 6'h26, 8'h56);
        issue(0, 1, 6'h26, 8'h56, 1);
        drop(0);
        expect_txn(0, 1, 6'h01, 8'h20);
        issue(0, 1, 6'h01, 8'h20, 1);
        drop(0);

        // Reset during XFER of an r0 read: strobe seen, ack never issued
        sq.push_back('{we: 1'b0, addr: 6'h06, wdata: 8'h00});
        r0_we = 1'b0; r0_addr = 6'h06; r0_wdata = 8'h00; r0_req = 1'b1;
        @(posedge clock);
        #1;
        reset  = 1'b1;
        r0_req = 1'b0;
        @(posedge clock);
        @(negedge clock);
        check("midrst_strobes", 32'({reg_write_en, reg_read_en}), 32'd0);
        check("midrst_acks", 32'({r0_ack, r1_ack, r0_err, r1_err}), 32'd0);
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_r0_rdata", 32'(r0_rdata), 32'd0);
        check("midrst_r1_rdata", 32'(r1_rdata), 32'd0);
        @(posedge clock);
        #1;
        reset     = 1'b0;
        exp_rd[0] = 8'h00;
        exp_rd[1] = 8'h00;
        repeat (6) @(posedge clock);
        #1;

        expect_txn(0, 1, 6'h04, 8'h01);
        expect_txn(1, 0, 6'h0F, 8'h00);
        fork
            begin issue(0, 1, 6'h04, 8'h01, 0); drop(0); end
            begin issue(1, 0, 6'h0F, 8'h00, 0); drop(1); end
        join
        @(posedge clock);
        #1;

        // req held through ack with a new command: each command served once
        expect_txn(0, 1, 6'h04, 8'h11);
        expect_txn(0, 1, 6'h06, 8'h22);
        issue(0, 1, 6'h04, 8'h11, 1);
        issue(0, 1, 6'h06, 8'h22, 1);
        drop(0);

        repeat (8) @(posedge clock);
        @(negedge clock);
        check("strobe_queue_drained", 32'(sq.size()), 32'd0);
        check("ack_queue_drained", 32'(aq.size()), 32'd0);
        check("final_busy", 32'(busy), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
